// File: rtl/am29520_pkg.sv
// Shared constants for the am29520 multilevel pipeline register.
// Build option: AM29520_INVERT_EN selects the inverting-output variant.
package am29520_pkg;

    localparam logic [1:0] I_LOADA  = 2'b00;
    localparam logic [1:0] I_LOADB  = 2'b01;
    localparam logic [1:0] I_SINGLE = 2'b10;
    localparam logic [1:0] I_HOLD   = 2'b11;

`ifdef AM29520_INVERT_EN
    localparam bit INVERT_OUT = 1'b1;
`else
    localparam bit INVERT_OUT = 1'b0;
`endif

    // Two stages still need one select bit.
    function automatic int sel_width(input int depth);
        return (2 * depth <= 2) ? 1 : $clog2(2 * depth);
    endfunction

endpackage

// File: rtl/am29520_bank.sv
// One bank of DEPTH shift stages; stage 0 is the input end.
module am29520_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     cp,
    input  logic                     clr_,
    input  logic                     i_shift_en,
    input  logic [WIDTH-1:0]         i_shift_in,
    output logic [DEPTH*WIDTH-1:0]   o_stages
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge cp or negedge clr_) begin
        if (!clr_) begin
            r_stage <= '0;
        end else if (i_shift_en) begin
            r_stage[0] <= i_shift_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_stages = r_stage;

endmodule

// File: rtl/am29520.sv
// Multilevel pipeline register: two DEPTH-stage banks, any stage muxed to a tristate bus.
// Build option: AM29520_INVERT_EN inverts the driven output.
module am29520
    import am29520_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int SELW = sel_width(DEPTH)
) (
    input  logic             cp,
    input  logic             clr_,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       i,
    input  logic [SELW-1:0]  s,
    input  logic             oe_,
    output logic [WIDTH-1:0] y
);

    logic [DEPTH-1:0][WIDTH-1:0]   w_a;
    logic [DEPTH-1:0][WIDTH-1:0]   w_b;
    logic [2*DEPTH-1:0][WIDTH-1:0] w_all;
    logic                          w_en_a;
    logic                          w_en_b;
    logic [WIDTH-1:0]              w_b_in;
    logic [WIDTH-1:0]              w_sel;

    assign w_en_a = (i == I_LOADA) || (i == I_SINGLE);
    assign w_en_b = (i == I_LOADB) || (i == I_SINGLE);
    // In single-chain mode B continues where A ends; the old A tail is taken.
    assign w_b_in = (i == I_SINGLE) ? w_a[DEPTH-1] : d;

    am29520_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank_a (
        .cp         (cp),
        .clr_       (clr_),
        .i_shift_en (w_en_a),
        .i_shift_in (d),
        .o_stages   (w_a)
    );

    am29520_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank_b (
        .cp         (cp),
        .clr_       (clr_),
        .i_shift_en (w_en_b),
        .i_shift_in (w_b_in),
        .o_stages   (w_b)
    );

    // Selects 0..DEPTH-1 land on A, the upper half on B.
    assign w_all = {w_b, w_a};
    assign w_sel = w_all[s];

    assign y = oe_ ? {WIDTH{1'bz}} : (INVERT_OUT ? ~w_sel : w_sel);

endmodule
